// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder definitions: default sizes, sort FSM encoding and the
// normalized min-sum scaling used by the check-node unit.
package ldpc_pkg;

  localparam int unsigned WIDTH_DEF = 6;
  localparam int unsigned DEG_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sort_state_t;

  // x0.75 normalization, (m>>1)+(m>>2); callers truncate to their width.
  function automatic logic [31:0] nms_scale(input logic [31:0] m);
    return (m >> 1) + (m >> 2);
  endfunction

endpackage

// File: rtl/abs_sat.sv
// Signed two's-complement value to saturated (WIDTH-1)-bit magnitude plus sign.
module abs_sat #(
  parameter int unsigned WIDTH = 6
) (
  input  logic signed [WIDTH-1:0] q,
  output logic        [WIDTH-2:0] mag,
  output logic                    sign
);

  logic [WIDTH-1:0] neg;

  assign sign = q[WIDTH-1];
  assign neg  = ~q + (WIDTH)'(1);

  // The most negative input has no positive counterpart; clamp it to all-ones.
  always_comb begin
    mag = q[WIDTH-2:0];
    if (sign) begin
      if (q[WIDTH-2:0] == '0) mag = '1;
      else                    mag = neg[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/cnu_min_sort.sv
// Serial min-sum front end of the CNU: tracks min1/min2, min1 index and edge
// signs over DEG samples, then pulses finish_bubble_sort for one cycle.
module cnu_min_sort
  import ldpc_pkg::*;
#(
  parameter  int unsigned WIDTH = WIDTH_DEF,
  parameter  int unsigned DEG   = DEG_DEF,
  localparam int unsigned IDXW  = $clog2(DEG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en_bubble_sort,
  input  logic signed [WIDTH-1:0] q_in,
  output logic                    finish_bubble_sort,
  output logic        [WIDTH-2:0] min1,
  output logic        [WIDTH-2:0] min2,
  output logic        [WIDTH-2:0] nmin1,
  output logic        [WIDTH-2:0] nmin2,
  output logic        [IDXW-1:0]  min1_idx,
  output logic                    sign_prod,
  output logic        [DEG-1:0]   sign_vec
);

  sort_state_t      state;
  logic [IDXW-1:0]  cnt;
  logic [WIDTH-2:0] mag;
  logic             sgn;

  abs_sat #(.WIDTH(WIDTH)) u_abs (
    .q    (q_in),
    .mag  (mag),
    .sign (sgn)
  );

  assign nmin1 = (WIDTH-1)'(nms_scale(32'(min1)));
  assign nmin2 = (WIDTH-1)'(nms_scale(32'(min2)));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state              <= IDLE;
      cnt                <= '0;
      min1               <= '0;
      min2               <= '0;
      min1_idx           <= '0;
      sign_prod          <= 1'b0;
      sign_vec           <= '0;
      finish_bubble_sort <= 1'b0;
    end else begin
      finish_bubble_sort <= 1'b0;
      case (state)
        IDLE: begin
          if (en_bubble_sort) begin
            min1      <= mag;
            min2      <= '1;
            min1_idx  <= '0;
            sign_vec  <= {{(DEG-1){1'b0}}, sgn};
            sign_prod <= sgn;
            cnt       <= (IDXW)'(1);
            state     <= RUN;
          end
        end
        RUN: begin
          if (en_bubble_sort) begin
            // Strict compares: ties keep the earliest index and feed min2.
            if (mag < min1) begin
              min2     <= min1;
              min1     <= mag;
              min1_idx <= cnt;
            end else if (mag < min2) begin
              min2 <= mag;
            end
            sign_vec[cnt] <= sgn;
            sign_prod     <= sign_prod ^ sgn;
            if (cnt == (IDXW)'(DEG-1)) begin
              cnt                <= '0;
              finish_bubble_sort <= 1'b1;
              state              <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnu_min_sort.sv
// Scoreboard bench for cnu_min_sort (WIDTH=6, DEG=4) with directed rows.
module tb_cnu_min_sort;

  localparam int unsigned W = 6;
  localparam int unsigned D = 4;

  typedef logic signed [W-1:0] row_t [D];

  typedef struct {
    logic [W-2:0] m1;
    logic [W-2:0] m2;
    logic [W-2:0] n1;
    logic [W-2:0] n2;
    logic [1:0]   idx;
    logic         sp;
    logic [D-1:0] sv;
    int unsigned  cyc;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                clr = 1'b0;
  logic                en  = 1'b0;
  logic signed [W-1:0] q_in = '0;
  logic                finish;
  logic [W-2:0]        min1, min2, nmin1, nmin2;
  logic [1:0]          min1_idx;
  logic                sign_prod;
  logic [D-1:0]        sign_vec;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;
  exp_t        sb[$];

  cnu_min_sort #(.WIDTH(W), .DEG(D)) dut (
    .clk                (clk),
    .rst                (rst),
    .clr                (clr),
    .en_bubble_sort     (en),
    .q_in               (q_in),
    .finish_bubble_sort (finish),
    .min1               (min1),
    .min2               (min2),
    .nmin1              (nmin1),
    .nmin2              (nmin2),
    .min1_idx           (min1_idx),
    .sign_prod          (sign_prod),
    .sign_vec           (sign_vec)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int m1, input int m2, input int n1, input int n2,
                              input int idx, input int sp, input int sv);
    exp_t e;
    e.m1 = m1[W-2:0]; e.m2 = m2[W-2:0]; e.n1 = n1[W-2:0]; e.n2 = n2[W-2:0];
    e.idx = idx[1:0]; e.sp = sp[0]; e.sv = sv[D-1:0]; e.cyc = 0;
    return e;
  endfunction

  // Monitor: every finish pulse is matched against the oldest expected row.
  always @(negedge clk) begin
    if (finish) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_finish: got finish=1 expected no finish (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("min1",         min1,      e.m1);
        chk("min2",         min2,      e.m2);
        chk("nmin1",        nmin1,     e.n1);
        chk("nmin2",        nmin2,     e.n2);
        chk("min1_idx",     min1_idx,  e.idx);
        chk("sign_prod",    sign_prod, e.sp);
        chk("sign_vec",     sign_vec,  e.sv);
        chk("finish_cycle", cyc,       e.cyc);
      end
    end
  end

  task automatic step(input logic e, input logic signed [W-1:0] v);
    @(posedge clk);
    #1;
    en   = e;
    q_in = v;
  endtask

  // Drives one row; npause idle cycles follow sample pause_after. The cycle
  // the FSM sits in DONE is driven with en low, as the controller does.
  task automatic run_row(input row_t s, input int pause_after, input int npause, input exp_t e);
    for (int i = 0; i < D; i++) begin
      step(1'b1, s[i]);
      if (i == 0) begin
        e.cyc = cyc + D + npause;
        sb.push_back(e);
      end
      if (i == pause_after) repeat (npause) step(1'b0, '0);
    end
    step(1'b0, '0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_finish"},   finish,    0);
    chk({tag, "_min1"},     min1,      0);
    chk({tag, "_min2"},     min2,      0);
    chk({tag, "_nmin2"},    nmin2,     0);
    chk({tag, "_min1_idx"}, min1_idx,  0);
    chk({tag, "_sign_prod"},sign_prod, 0);
    chk({tag, "_sign_vec"}, sign_vec,  0);
  endtask

  initial begin
    int unsigned w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run_row('{6'sd5, -6'sd3, 6'sd7, -6'sd2},     -1, 0, mk(2, 3, 1, 1, 3, 0, 4'b1010));
    run_row('{-6'sd32, -6'sd32, -6'sd32, -6'sd32}, -1, 0, mk(31, 31, 22, 22, 0, 0, 4'b1111));
    run_row('{6'sd4, 6'sd4, 6'sd4, 6'sd4},       -1, 0, mk(4, 4, 3, 3, 0, 0, 4'b0000));
    run_row('{6'sd9, 6'sd1, 6'sd6, -6'sd1},       1, 2, mk(1, 1, 0, 0, 1, 1, 4'b1000));

    // Abort via rst after two samples, then a clean row.
    step(1'b1, 6'sd3);
    step(1'b1, 6'sd2);
    @(posedge clk);
    #1 rst = 1'b1; en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_zero("abort_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    run_row('{6'sd3, 6'sd2, 6'sd8, 6'sd5},       -1, 0, mk(2, 3, 1, 1, 1, 0, 4'b0000));

    // Abort via clr coinciding with a sample, which must be discarded.
    step(1'b1, 6'sd1);
    step(1'b1, -6'sd1);
    @(posedge clk);
    #1 clr = 1'b1; en = 1'b1; q_in = 6'sd7;
    @(posedge clk);
    #1 clr = 1'b0; en = 1'b0;
    run_row('{-6'sd5, 6'sd13, -6'sd9, 6'sd4},    -1, 0, mk(4, 5, 3, 3, 3, 0, 4'b0101));

    // Back-to-back rows: second first-sample lands right after DONE.
    run_row('{-6'sd1, 6'sd7, -6'sd6, 6'sd3},     -1, 0, mk(1, 3, 0, 1, 0, 0, 4'b0101));
    run_row('{6'sd10, -6'sd12, 6'sd15, 6'sd11},  -1, 0, mk(10, 11, 7, 7, 0, 1, 4'b0010));

    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL finish_timeout: got %0d rows pending expected 0", sb.size());
    end
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
